// File: rtl/frame_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_reader_pkg                                                           |
// | Shared definitions for the display-side SPRAM read path: top-level state   |
// | codes shared with the frame writer, source image geometry, pixel width     |
// | and the reader FSM encoding.                                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package frame_reader_pkg;

   // Top-level system state codes, common to the writer and the reader
   localparam logic [7:0] ST_WAIT = 8'h01;
   localparam logic [7:0] ST_XFER = 8'h02;
   localparam logic [7:0] ST_SHOW = 8'h03;

   // Source image geometry and pixel format (RGB444)
   localparam int IMG_W  = 50;
   localparam int IMG_H  = 40;
   localparam int PIX_W  = 12;
   localparam int ADDR_W = 15;

   // Reader display-gating FSM
   typedef enum logic [1:0] {
      FSM_EMPTY   = 2'd0,
      FSM_ARMED   = 2'd1,
      FSM_SHOW    = 2'd2,
      FSM_BLOCKED = 2'd3
   } fsm_t;

endpackage : frame_reader_pkg
`default_nettype wire

// File: rtl/frame_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_reader_if                                                            |
// | Raster input, SPRAM read port and pixel output bundle of the frame reader. |
// | The reader connects through the slave modport; the raster/SPRAM side       |
// | connects through the master modport.                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface frame_reader_if;
   import frame_reader_pkg::*;

   // Display raster
   logic [9:0]        x_addr;
   logic [9:0]        y_addr;
   logic              pix_de;
   // SPRAM read port
   logic [PIX_W-1:0]  spram_rd_data;
   logic              spram_rd_req;
   logic [ADDR_W-1:0] spram_addr;
   // Pixel stream back to the display
   logic [PIX_W-1:0]  pixel_data;
   logic              pixel_de;

   modport master (
      output x_addr, y_addr, pix_de, spram_rd_data,
      input  spram_rd_req, spram_addr, pixel_data, pixel_de
   );

   modport slave (
      input  x_addr, y_addr, pix_de, spram_rd_data,
      output spram_rd_req, spram_addr, pixel_data, pixel_de
   );

endinterface : frame_reader_if
`default_nettype wire

// File: rtl/frame_reader_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_reader_delay                                                         |
// | Fixed-depth shift register that carries per-pixel flags alongside the      |
// | SPRAM read so they line up with the returned data.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module frame_reader_delay #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_d [DEPTH];
   logic [WIDTH-1:0] stage_q [DEPTH];

   // Each stage takes the previous one; stage 0 takes the input
   always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Shift register with synchronous clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule : frame_reader_delay
`default_nettype wire

// File: rtl/frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_reader                                                               |
// | Display-side read path for the photo-frame image buffer. Maps raster       |
// | coordinates to scaled, centred SPRAM addresses, returns pixel data aligned |
// | to the raster, and only shows a frame once the writer has stored it fully. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module frame_reader
   import frame_reader_pkg::*;
#(
   parameter int               W          = IMG_W,
   parameter int               H          = IMG_H,
   parameter int               SCALE_LOG2 = 3,
   parameter int               X_OFS      = 120,
   parameter int               Y_OFS      = 80,
   parameter int               RD_LAT     = 2,
   parameter logic [PIX_W-1:0] BG_COLOR   = 12'h000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          state,
   input  logic                image_complete,
   input  logic                image_receiving,
   output logic                image_shown,
   frame_reader_if.slave       bus
);

   // Window edges in display pixels; the upper bounds are exclusive
   localparam logic [9:0]        X_LO   = 10'(X_OFS);
   localparam logic [9:0]        X_HI   = 10'(X_OFS + (W << SCALE_LOG2));
   localparam logic [9:0]        Y_LO   = 10'(Y_OFS);
   localparam logic [9:0]        Y_HI   = 10'(Y_OFS + (H << SCALE_LOG2));
   localparam logic [ADDR_W-1:0] W_ADDR = ADDR_W'(W);

   logic st_wait, st_xfer, st_show;
   logic frame_start;

   fsm_t fsm_d, fsm_q;
   logic done_d, done_q;

   logic [9:0]        dx, dy, sx, sy;
   logic              s0_win_d, s0_win_q;
   logic              s0_de_d, s0_de_q;
   logic [ADDR_W-1:0] s0_addr_d, s0_addr_q;

   logic              fetch;
   logic              rd_req_d, rd_req_q;
   logic [ADDR_W-1:0] rd_addr_d, rd_addr_q;

   logic [1:0]        dly_in, dly_out;
   logic              dly_fetch, dly_de;
   logic [PIX_W-1:0]  pixel_data_d, pixel_data_q;
   logic              pixel_de_d, pixel_de_q;

   assign st_wait     = (state == ST_WAIT);
   assign st_xfer     = (state == ST_XFER);
   assign st_show     = (state == ST_SHOW);
   assign frame_start = bus.pix_de && (bus.x_addr == 10'd0) && (bus.y_addr == 10'd0);

   // Done latch: remembers a complete frame after the writer drops its flag;
   // a fresh image_complete wins over any clearing condition in the same cycle
   always_comb begin
      done_d = done_q;
      if (st_wait || st_xfer || image_receiving) begin
         done_d = 1'b0;
      end
      if (image_complete) begin
         done_d = 1'b1;
      end
   end

   // Display-gating FSM next state; returning to WAIT overrides everything
   always_comb begin
      fsm_d = fsm_q;
      if (st_wait) begin
         fsm_d = FSM_EMPTY;
      end else begin
         case (fsm_q)
            FSM_EMPTY:   if (done_q) fsm_d = FSM_ARMED;
            FSM_ARMED:   if (frame_start && st_show) fsm_d = FSM_SHOW;
            FSM_SHOW:    if (image_receiving || st_xfer) fsm_d = FSM_BLOCKED;
            FSM_BLOCKED: if (done_q) fsm_d = FSM_ARMED;
            default:     fsm_d = FSM_EMPTY;
         endcase
      end
   end

   // Stage 0: window test and scaled address; offsets are only formed inside
   // the window so out-of-window coordinates never underflow into an address
   always_comb begin
      s0_win_d = (bus.x_addr >= X_LO) && (bus.x_addr < X_HI) &&
                 (bus.y_addr >= Y_LO) && (bus.y_addr < Y_HI);
      s0_de_d  = bus.pix_de;
      dx       = '0;
      dy       = '0;
      if (s0_win_d) begin
         dx = bus.x_addr - X_LO;
         dy = bus.y_addr - Y_LO;
      end
      sx        = dx >> SCALE_LOG2;
      sy        = dy >> SCALE_LOG2;
      s0_addr_d = ADDR_W'(sy) * W_ADDR + ADDR_W'(sx);
   end

   // Stage 1: issue the read; live writer activity suppresses it on the same
   // edge the FSM leaves SHOW, and the address holds between fetches
   always_comb begin
      fetch     = s0_de_q && s0_win_q && (fsm_q == FSM_SHOW) && st_show && !image_receiving;
      rd_req_d  = fetch;
      rd_addr_d = fetch ? s0_addr_q : rd_addr_q;
   end

   assign dly_in    = {fetch, s0_de_q};
   assign dly_fetch = dly_out[1];
   assign dly_de    = dly_out[0];

   frame_reader_delay #(
      .DEPTH (RD_LAT + 1),
      .WIDTH (2)
   ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (dly_in),
      .dout  (dly_out)
   );

   // Output stage: show returned data only if the read was real and the FSM
   // has not been emptied or blocked by this edge; otherwise background
   always_comb begin
      pixel_de_d   = dly_de;
      pixel_data_d = BG_COLOR;
      if (dly_fetch && (fsm_d != FSM_EMPTY) && (fsm_d != FSM_BLOCKED)) begin
         pixel_data_d = bus.spram_rd_data;
      end
   end

   // State and pipeline registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q        <= FSM_EMPTY;
         done_q       <= 1'b0;
         s0_win_q     <= 1'b0;
         s0_de_q      <= 1'b0;
         s0_addr_q    <= '0;
         rd_req_q     <= 1'b0;
         rd_addr_q    <= '0;
         pixel_data_q <= '0;
         pixel_de_q   <= 1'b0;
      end else begin
         fsm_q        <= fsm_d;
         done_q       <= done_d;
         s0_win_q     <= s0_win_d;
         s0_de_q      <= s0_de_d;
         s0_addr_q    <= s0_addr_d;
         rd_req_q     <= rd_req_d;
         rd_addr_q    <= rd_addr_d;
         pixel_data_q <= pixel_data_d;
         pixel_de_q   <= pixel_de_d;
      end
   end

   assign bus.spram_rd_req = rd_req_q;
   assign bus.spram_addr   = rd_addr_q;
   assign bus.pixel_data   = pixel_data_q;
   assign bus.pixel_de     = pixel_de_q;
   assign image_shown      = (fsm_q == FSM_SHOW);

endmodule : frame_reader
`default_nettype wire

// File: tb/tb_frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_frame_reader                                                            |
// | Self-checking bench for frame_reader: cycle model of the gating FSM and    |
// | address path, scoreboard queue for the pixel return path, and a simple     |
// | two-cycle SPRAM model returning address-derived data.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_frame_reader;
   import frame_reader_pkg::*;

   localparam int RD_LAT = 2;

   typedef struct packed {
      logic        fetch;
      logic        de;
      logic [14:0] addr;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] state;
   logic       image_complete;
   logic       image_receiving;
   logic       image_shown;

   frame_reader_if bus ();

   frame_reader #(.RD_LAT(RD_LAT)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .state           (state),
      .image_complete  (image_complete),
      .image_receiving (image_receiving),
      .image_shown     (image_shown),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] mem_f(input logic [14:0] a);
      return a[11:0] ^ 12'h5A3;
   endfunction

   // SPRAM model: address registered, then data registered (two cycles)
   logic [14:0] mem_a1;
   logic [11:0] mem_d;
   always @(posedge clk) begin
      mem_a1 <= bus.spram_addr;
      mem_d  <= mem_f(mem_a1);
   end
   assign bus.spram_rd_data = mem_d;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   fsm_t        m_fsm;
   logic        m_done;
   logic        m_win;
   logic        m_de;
   logic [14:0] m_addr;
   logic [14:0] m_addr_q;
   ent_t        sb[$];

   // One clock: drive inputs, advance model, compare outputs after the edge
   task automatic tick(input logic r, input logic [7:0] st, input logic c, input logic rc,
                       input int x, input int y, input logic de);
      logic        fetch;
      fsm_t        nf;
      logic        nd;
      logic        nwin;
      logic [14:0] naddr;
      ent_t        e;
      ent_t        o;
      logic [11:0] exp_pix;

      rst_n           = r;
      state           = st;
      image_complete  = c;
      image_receiving = rc;
      bus.x_addr      = 10'(x);
      bus.y_addr      = 10'(y);
      bus.pix_de      = de;

      fetch = m_de && m_win && (m_fsm == FSM_SHOW) && (st == 8'h03) && !rc;
      nd = m_done;
      if (st == 8'h01 || st == 8'h02 || rc) nd = 1'b0;
      if (c) nd = 1'b1;
      nf = m_fsm;
      if (st == 8'h01) nf = FSM_EMPTY;
      else begin
         case (m_fsm)
            FSM_EMPTY:   if (m_done) nf = FSM_ARMED;
            FSM_ARMED:   if (de && x == 0 && y == 0 && st == 8'h03) nf = FSM_SHOW;
            FSM_SHOW:    if (rc || st == 8'h02) nf = FSM_BLOCKED;
            FSM_BLOCKED: if (m_done) nf = FSM_ARMED;
            default:     nf = FSM_EMPTY;
         endcase
      end
      nwin  = (x >= 120) && (x < 520) && (y >= 80) && (y < 400);
      naddr = nwin ? 15'(((y - 80) / 8) * 50 + (x - 120) / 8) : 15'd0;

      @(posedge clk);
      #1;
      if (!r) begin
         m_fsm = FSM_EMPTY; m_done = 1'b0; m_win = 1'b0; m_de = 1'b0;
         m_addr = '0; m_addr_q = '0;
         sb.delete();
         for (int i = 0; i < RD_LAT + 1; i++) sb.push_back('0);
         check_eq("rst_req",   32'(bus.spram_rd_req), 32'd0);
         check_eq("rst_addr",  32'(bus.spram_addr),   32'd0);
         check_eq("rst_pix",   32'(bus.pixel_data),   32'd0);
         check_eq("rst_de",    32'(bus.pixel_de),     32'd0);
         check_eq("rst_shown", 32'(image_shown),      32'd0);
      end else begin
         e.fetch = fetch;
         e.de    = m_de;
         e.addr  = m_addr;
         if (fetch) m_addr_q = m_addr;
         m_fsm  = nf;
         m_done = nd;
         m_win  = nwin;
         m_de   = de;
         m_addr = naddr;
         check_eq("rd_req", 32'(bus.spram_rd_req), 32'(fetch));
         check_eq("addr",   32'(bus.spram_addr),   32'(m_addr_q));
         check_eq("shown",  32'(image_shown),      32'(m_fsm == FSM_SHOW));
         sb.push_back(e);
         if (sb.size() > RD_LAT + 1) begin
            o = sb.pop_front();
            exp_pix = (o.fetch && m_fsm != FSM_EMPTY && m_fsm != FSM_BLOCKED)
                      ? mem_f(o.addr) : 12'h000;
            check_eq("pixel",  32'(bus.pixel_data), 32'(exp_pix));
            check_eq("pix_de", 32'(bus.pixel_de),   32'(o.de));
         end
      end
      @(negedge clk);
   endtask

   task automatic pix(input int x, input int y);
      tick(1'b1, 8'h03, 1'b0, 1'b0, x, y, 1'b1);
   endtask

   task automatic idle(input int n, input logic [7:0] st);
      for (int i = 0; i < n; i++) tick(1'b1, st, 1'b0, 1'b0, 0, 5, 1'b0);
   endtask

   initial begin
      // Reset and idle in WAIT
      tick(1'b0, 8'h01, 1'b0, 1'b0, 0, 0, 1'b0);
      tick(1'b0, 8'h01, 1'b0, 1'b0, 0, 0, 1'b0);
      idle(3, 8'h01);

      // Transfer, complete pulse on the last XFER cycle, then enter display mid-frame
      for (int i = 0; i < 3; i++) tick(1'b1, 8'h02, 1'b0, 1'b1, 0, 0, 1'b0);
      tick(1'b1, 8'h02, 1'b1, 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 6; i++) pix(200 + i, 100);

      // Frame start arms display; outside the window gives background
      pix(0, 0);
      for (int i = 0; i < 5; i++) pix(5 + i, 5);

      // Address corners and window edges
      pix(120, 80);  pix(127, 87);  pix(128, 80);  pix(519, 399);
      pix(520, 80);  pix(119, 80);  pix(300, 79);  pix(300, 400);
      pix(135, 95);  pix(400, 200);
      idle(5, 8'h03);

      // Random raster traffic, mixed pix_de
      for (int i = 0; i < 40; i++)
         tick(1'b1, 8'h03, 1'b0, 1'b0, int'($urandom_range(540, 100)),
              int'($urandom_range(420, 60)), logic'($urandom_range(1, 0)));
      idle(5, 8'h03);

      // Block with reads in flight, then re-arm with a new image
      for (int i = 0; i < 4; i++) pix(200 + 8 * i, 150);
      tick(1'b1, 8'h03, 1'b0, 1'b1, 240, 150, 1'b1);
      for (int i = 0; i < 3; i++) tick(1'b1, 8'h03, 1'b0, 1'b1, 250 + i, 150, 1'b1);
      for (int i = 0; i < 3; i++) pix(260 + 8 * i, 160);
      tick(1'b1, 8'h03, 1'b1, 1'b0, 300, 160, 1'b1);
      pix(310, 160);
      pix(0, 0);
      for (int i = 0; i < 6; i++) pix(320 + 8 * i, 170);
      idle(5, 8'h03);

      // Reset in the middle of SHOW; stays empty afterwards
      for (int i = 0; i < 2; i++) pix(330 + 8 * i, 180);
      tick(1'b0, 8'h03, 1'b0, 1'b0, 350, 180, 1'b1);
      for (int i = 0; i < 4; i++) pix(360 + 8 * i, 180);
      pix(0, 0);
      for (int i = 0; i < 3; i++) pix(200, 200);

      // New image, show it, then WAIT empties; no image without a fresh complete
      tick(1'b1, 8'h03, 1'b1, 1'b0, 0, 5, 1'b0);
      idle(2, 8'h03);
      pix(0, 0);
      for (int i = 0; i < 4; i++) pix(140 + 8 * i, 90);
      tick(1'b1, 8'h01, 1'b0, 1'b0, 180, 90, 1'b1);
      idle(2, 8'h01);
      pix(0, 0);
      for (int i = 0; i < 6; i++) pix(150 + 8 * i, 100);
      idle(6, 8'h03);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_frame_reader
`default_nettype wire
